// File: rtl/adder_gear_ec_pkg.sv
// gear_pkg: shared types and geometry helpers for the error-correcting GeAr adder.
package gear_pkg;

    typedef enum logic {IDLE, BUSY} gear_ec_state_t;

    localparam int STAT_W = 32;

    // Number of windows of L=r+p bits needed to cover n bits in steps of r.
    function automatic int gear_k(input int n, input int r, input int p);
        return (r < 1 || n <= r + p) ? 1 : (n - p - 1) / r + 1;
    endfunction

endpackage

// File: rtl/adder_gear_window.sv
// adder_gear_window: one L-bit GeAr window adder with carry-in, plus its carry out of the low R bits.
module adder_gear_window #(
    parameter int R = 4,
    parameter int P = 4,
    localparam int L = R + P
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         cin,
    output logic [L:0]   w,
    output logic         g
);

    logic [R:0] lo;

    assign w  = {1'b0, a} + {1'b0, b} + (L+1)'(cin);
    assign lo = {1'b0, a[R-1:0]} + {1'b0, b[R-1:0]} + (R+1)'(cin);
    assign g  = lo[R];

endmodule

// File: rtl/adder_gear_ec.sv
// adder_gear_ec: GeAr approximate adder with budget-limited iterative carry correction behind valid/ready.
// Define ADDER_GEAR_EC_STATS_EN to add result/correction/inexact statistics counters.
module adder_gear_ec
    import gear_pkg::*;
#(
    parameter int R    = 4,
    parameter int P    = 4,
    parameter int IP_W = 16,
    parameter int OC_W = 16,
    localparam int N    = (IP_W > OC_W) ? IP_W : OC_W,
    localparam int L    = R + P,
    localparam int K    = gear_k(N, R, P),
    localparam int NE   = L + (K - 1) * R,
    localparam int CL_W = ($clog2(K) > 1) ? $clog2(K) : 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IP_W-1:0] i_p,
    input  logic [OC_W-1:0] i_c,
    input  logic [CL_W-1:0] i_corr_lvl,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [OC_W-1:0] o_c,
    output logic            o_approx,
    output logic [CL_W-1:0] o_ncorr
`ifdef ADDER_GEAR_EC_STATS_EN
    ,
    input  logic              i_stat_clr,
    output logic [STAT_W-1:0] o_stat_ops,
    output logic [STAT_W-1:0] o_stat_corr,
    output logic [STAT_W-1:0] o_stat_inexact
`endif
);

    localparam logic [CL_W-1:0] KM1 = CL_W'(K - 1);

    if (P < 1 || R < 1 || N < L) begin : g_bad_cfg
        $error("adder_gear_ec: requires P>=1, R>=1 and max(IP_W,OC_W)>=R+P");
    end

    gear_ec_state_t  state_q, state_d;
    logic [NE-1:0]   a_q, a_d, b_q, b_d, sum;
    logic [K-1:0]    cin_q, cin_d, g, g_prev, flag, fix;
    logic [CL_W-1:0] cnt_q, cnt_d, lvl_q, lvl_d;
    logic [L:0]      w [K];
    logic            busy, done, cap;

    for (genvar i = 0; i < K; i++) begin : g_win
        adder_gear_window #(.R(R), .P(P)) u_win (
            .a  (a_q[i*R +: L]),
            .b  (b_q[i*R +: L]),
            .cin(cin_q[i]),
            .w  (w[i]),
            .g  (g[i])
        );
        if (i == 0) begin : g_lo
            assign sum[L-1:0] = w[0][L-1:0];
        end else begin : g_hi
            assign sum[i*R+P +: R] = w[i][P +: R];
        end
    end

    // g_prev[j] is the carry window j-1 predicts into window j; bit 0 never flags.
    always_comb begin
        g_prev = '0;
        for (int j = 1; j < K; j++) g_prev[j] = g[j-1];
    end

    assign flag     = g_prev ^ cin_q;
    assign fix      = flag & (~flag + K'(1));
    assign busy     = state_q == BUSY;
    assign done     = (flag == '0) || (cnt_q >= lvl_q);
    assign o_valid  = busy && done;
    assign o_ready  = !busy || (done && i_ready);
    assign cap      = i_valid && o_ready;
    assign o_c      = busy ? sum[OC_W-1:0] : '0;
    assign o_approx = busy && (flag != '0);
    assign o_ncorr  = cnt_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        lvl_d   = lvl_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        if (cap) begin
            state_d = BUSY;
            a_d     = NE'($signed(i_p));
            b_d     = NE'($signed(i_c));
            lvl_d   = (i_corr_lvl > KM1) ? KM1 : i_corr_lvl;
            cin_d   = '0;
            cnt_d   = '0;
        end else if (busy && !done) begin
            cin_d = (cin_q & ~fix) | (g_prev & fix);
            cnt_d = cnt_q + CL_W'(1);
        end else if (busy && i_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            lvl_q   <= '0;
            cin_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lvl_q   <= lvl_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ADDER_GEAR_EC_STATS_EN
    logic [STAT_W-1:0] ops_q, ops_d, corr_q, corr_d, inex_q, inex_d;
    logic [STAT_W:0]   corr_sum;

    always_comb begin
        corr_sum = {1'b0, corr_q} + (STAT_W+1)'(cnt_q);
        ops_d    = ops_q;
        corr_d   = corr_q;
        inex_d   = inex_q;
        if (i_stat_clr) begin
            ops_d  = '0;
            corr_d = '0;
            inex_d = '0;
        end else if (o_valid && i_ready) begin
            ops_d  = (&ops_q) ? ops_q : ops_q + STAT_W'(1);
            corr_d = corr_sum[STAT_W] ? '1 : corr_sum[STAT_W-1:0];
            inex_d = (o_approx && !(&inex_q)) ? inex_q + STAT_W'(1) : inex_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ops_q  <= '0;
            corr_q <= '0;
            inex_q <= '0;
        end else begin
            ops_q  <= ops_d;
            corr_q <= corr_d;
            inex_q <= inex_d;
        end
    end

    assign o_stat_ops     = ops_q;
    assign o_stat_corr    = corr_q;
    assign o_stat_inexact = inex_q;
`endif

endmodule
